// File: rtl/bfm_alu_pkg.sv
// -----------------------------------------------------------------------------
// bfm_alu_pkg
// Shared constants, types and helpers for the bfm_alu arithmetic model.
//   DEFAULT_WIDTH : default operand/result width in bits
//   MAX_LATENCY   : largest supported pipeline depth
//   bfm_word_t    : DEFAULT_WIDTH-bit data word
//   sat_add()     : DEFAULT_WIDTH-bit unsigned add that clamps at all-ones
// -----------------------------------------------------------------------------
package bfm_alu_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_LATENCY   = 4;

    typedef logic [DEFAULT_WIDTH-1:0] bfm_word_t;

    // The carry out of the extended sum is the unsigned overflow flag.
    function automatic bfm_word_t sat_add(input bfm_word_t a, input bfm_word_t b);
        logic [DEFAULT_WIDTH:0] sum_ext;
        sum_ext = {1'b0, a} + {1'b0, b};
        return sum_ext[DEFAULT_WIDTH] ? '1 : sum_ext[DEFAULT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/bfm_alu_pipe_stage.sv
// -----------------------------------------------------------------------------
// bfm_alu_pipe_stage
// One WIDTH-bit delay register with asynchronous active-low clear.
// Ports:
//   clk_i   : clock, rising edge
//   reset_i : asynchronous clear, active low
//   d       : data in
//   q       : data out, one clock later
// -----------------------------------------------------------------------------
module bfm_alu_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: reset sits in the sensitivity list so the clear acts without a
    // clock edge; state is written with <= so every stage samples the
    // pre-edge value of its neighbour.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/bfm_alu.sv
// -----------------------------------------------------------------------------
// bfm_alu
// Free-running registered two-operand adder. A_s and B_s are sampled on every
// rising edge; their sum appears on res_o LATENCY clocks later. There is no
// handshake and no stall: one result per clock.
// Parameters:
//   WIDTH   : operand/result width (default 8)
//   LATENCY : register stages from operand sample to res_o, 1..4
// Ports:
//   clk_i   : clock, rising edge
//   reset_i : asynchronous reset, active low; clears all stages and res_o
//   A_s     : operand A
//   B_s     : operand B
//   res_o   : registered result
// Build option:
//   BFM_ALU_SAT_EN : when defined, an unsigned overflow clamps the result to
//                    all-ones instead of wrapping modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module bfm_alu
    import bfm_alu_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LATENCY = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] A_s,
    input  logic [WIDTH-1:0] B_s,
    output logic [WIDTH-1:0] res_o
);

    generate
        if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
            $error("bfm_alu: LATENCY must be in 1..%0d", MAX_LATENCY);
        end
    endgenerate

    logic [WIDTH-1:0] stage0_d;
    logic [WIDTH-1:0] stage0_q;
    logic [WIDTH-1:0] chain [LATENCY];

`ifdef BFM_ALU_SAT_EN
    // Overflow is decided here, in stage 0, so later stages only move data.
    logic [WIDTH:0] sum_ext;
    assign sum_ext  = {1'b0, A_s} + {1'b0, B_s};
    assign stage0_d = sum_ext[WIDTH] ? '1 : sum_ext[WIDTH-1:0];
`else
    // Keeping only WIDTH bits of the sum is the modulo-2^WIDTH wrap.
    assign stage0_d = A_s + B_s;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stage0_q <= '0;
        end else begin
            stage0_q <= stage0_d;
        end
    end

    assign chain[0] = stage0_q;

    // Stages 1..LATENCY-1 carry the stage-0 value forward unchanged.
    generate
        for (genvar i = 1; i < LATENCY; i++) begin : g_stage
            bfm_alu_pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .d       (chain[i-1]),
                .q       (chain[i])
            );
        end
    endgenerate

    assign res_o = chain[LATENCY-1];

endmodule

// File: tb/tb_bfm_alu.sv
// -----------------------------------------------------------------------------
// tb_bfm_alu
// Drives one operand stream into four bfm_alu instances (LATENCY 1..4) and
// compares each result against a reference: the arithmetic sum of the
// operands sampled LATENCY edges earlier, or zero if that sample was lost to
// reset. Define BFM_ALU_SAT_EN for the bench as well as the RTL to check the
// saturating build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bfm_alu;

    localparam int NDUT = 4;

    logic       clk_i   = 1'b0;
    logic       reset_i = 1'b0;
    logic [7:0] A_s     = 8'h00;
    logic [7:0] B_s     = 8'h00;
    logic [7:0] res [NDUT];

    int tests_run = 0;
    int tests_failed = 0;

    // hist[k] = expected value of the sample taken k edges ago (0 = newest)
    logic [7:0] hist [NDUT];

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        bfm_alu #(
            .WIDTH   (8),
            .LATENCY (g + 1)
        ) u_dut (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .A_s     (A_s),
            .B_s     (B_s),
            .res_o   (res[g])
        );
    end

    function automatic logic [7:0] ref_sum(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'(a) + int'(b);
`ifdef BFM_ALU_SAT_EN
        if (s > 255) return 8'hFF;
`endif
        return 8'(s % 256);
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NDUT; i++) hist[i] = 8'h00;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s L%0d", tag, i + 1), res[i], hist[i]);
        end
    endtask

    // Apply operands at the falling edge, clock them in, check at the next
    // falling edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input string tag);
        A_s = a;
        B_s = b;
        @(posedge clk_i);
        if (reset_i) begin
            for (int i = NDUT - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = ref_sum(a, b);
        end
        @(negedge clk_i);
        check_all(tag);
    endtask

    initial begin
        clear_model();

        // Held in reset while the clock runs: every output stays zero.
        @(negedge clk_i);
        for (int c = 0; c < 3; c++) step(8'h11, 8'h22, "reset_hold");

        // Release between edges; constant operands for 2000 cycles.
        reset_i = 1'b1;
        for (int c = 0; c < 2000; c++) step(8'd1, 8'd2, "const_add");
        check("const_add final L1", res[0], 8'h03);
        check("const_add final L4", res[3], 8'h03);

        // Back-to-back distinct samples: the LATENCY=3 instance shows 2,4,6
        // on edges 3,4,5 counted from the first sample.
        step(8'd1, 8'd1, "stream");
        step(8'd2, 8'd2, "stream");
        step(8'd3, 8'd3, "stream");
        check("stream L3 e3", res[2], 8'd2);
        step(8'd0, 8'd0, "stream");
        check("stream L3 e4", res[2], 8'd4);
        step(8'd0, 8'd0, "stream");
        check("stream L3 e5", res[2], 8'd6);

        // Overflow and the all-ones-without-carry boundary.
        for (int c = 0; c < NDUT; c++) step(8'hF0, 8'h20, "overflow");
`ifdef BFM_ALU_SAT_EN
        check("overflow const", res[3], 8'hFF);
`else
        check("overflow const", res[3], 8'h10);
`endif
        for (int c = 0; c < NDUT; c++) step(8'hFF, 8'h00, "ff_plus_0");
        check("ff_plus_0 const", res[3], 8'hFF);
        for (int c = 0; c < NDUT; c++) step(8'hFF, 8'h01, "ff_plus_1");

        // Reset pulse between edges while nonzero values are in flight.
        for (int c = 0; c < NDUT; c++) step(8'(c + 5), 8'(c + 9), "pre_reset");
        #2 reset_i = 1'b0;
        clear_model();
        #1 check_all("async_reset");
        #1 reset_i = 1'b1;
        for (int c = 0; c < 8; c++) step(8'(8 * c + 3), 8'(c + 40), "post_reset");

        // Random regression.
        for (int c = 0; c < 10000; c++) begin
            step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
